// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage types: the packet handed to decode
// and the fetch control states.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    FS_RUN   = 2'd0,
    FS_DRAIN = 2'd1,
    FS_HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] address;
  } fetch_pkt_t;

  localparam int unsigned FETCH_PKT_W = $bits(fetch_pkt_t);

  function automatic logic word_aligned(
    input logic [31:0] a
  );
    return a[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Synchronous prefetch FIFO with clear and
// same-cycle push/pop when full.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clock,
  input  logic                       nreset,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             empty, full;
  logic             do_push, do_pop;

  assign empty   = cnt_q == '0;
  assign full    = cnt_q == CW'(DEPTH);
  assign do_pop  = pop_i && !empty;
  // a full FIFO still takes a push when the head leaves
  assign do_push = push_i && (!full || do_pop);
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(do_push)
                    - CW'(do_pop);
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !clear_i)
      mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/instruction_fetch.sv
// RV32E fetch stage: PC, credit-limited word fetch,
// prefetch buffering and redirect draining.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned DEPTH        = 2
) (
  input  logic        clock,
  input  logic        nreset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        mem_resp_error,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_address,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        fault
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;

  logic [31:0]   aq_q [DEPTH];
  logic [AW-1:0] aq_wr_q, aq_rd_q;

  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   used;
  logic          credit;
  logic          req_fire, resp, pop;
  logic          push, clear;
  fetch_pkt_t    push_pkt, head_pkt;

  assign resp     = mem_resp_valid
                 && (outst_q != '0);
  assign req_fire = mem_req_valid && mem_req_ready;
  assign pop      = out_valid && out_ready;

  // a head leaving this cycle frees its slot at once
  assign used   = {1'b0, outst_q}
                + {1'b0, fifo_cnt}
                - (CW+1)'(pop);
  assign credit = used < (CW+1)'(DEPTH);

  assign out_valid = (fifo_cnt != '0)
                  && (state_q != FS_HALT);
  assign mem_req_addr    = pc_q;
  assign out_instruction = head_pkt.instruction;
  assign out_address     = head_pkt.address;

  assign push_pkt.instruction = mem_resp_data;
  assign push_pkt.address     = aq_q[aq_rd_q];
  assign clear                = redirect_valid;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FETCH_PKT_W)
  ) u_fifo (
    .clock   (clock),
    .nreset  (nreset),
    .clear_i (clear),
    .push_i  (push),
    .data_i  (push_pkt),
    .pop_i   (pop),
    .data_o  (head_pkt),
    .count_o (fifo_cnt)
  );

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q   <= FS_RUN;
      pc_q      <= RESET_VECTOR;
      outst_q   <= '0;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    push      = 1'b0;
    outst_d   = outst_q + CW'(req_fire)
                        - CW'(resp);
    if (req_fire)
      pc_d = pc_q + 32'd4;
    if (redirect_valid) begin
      pc_d      = redirect_target;
      discard_d = outst_q - CW'(resp);
      if (!word_aligned(redirect_target))
        state_d = FS_HALT;
      else if (discard_d != '0)
        state_d = FS_DRAIN;
      else
        state_d = FS_RUN;
    end else begin
      unique case (state_q)
        FS_RUN: begin
          if (resp) begin
            if (mem_resp_error)
              state_d = FS_HALT;
            else
              push = 1'b1;
          end
        end
        FS_DRAIN: begin
          if (resp && discard_q != '0)
            discard_d = discard_q - 1'b1;
          if (discard_q == '0
              || (resp && discard_q == CW'(1)))
            state_d = FS_RUN;
        end
        FS_HALT: ;
        default: state_d = FS_RUN;
      endcase
    end
  end

  always_comb begin
    mem_req_valid = 1'b0;
    fault         = 1'b0;
    unique case (state_q)
      FS_RUN:
        mem_req_valid = nreset && credit
                     && !redirect_valid;
      FS_DRAIN: ;
      FS_HALT:
        fault = 1'b1;
      default: ;
    endcase
  end

  // request addresses travel alongside outstanding fetches
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      aq_wr_q <= '0;
      aq_rd_q <= '0;
    end else begin
      if (req_fire) aq_wr_q <= aq_wr_q + 1'b1;
      if (resp)     aq_rd_q <= aq_rd_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (req_fire)
      aq_q[aq_wr_q] <= pc_q;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomised and directed bench for instruction_fetch
// against an in-order memory and program-order model.
module tb_instruction_fetch;

  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam int unsigned DEPTH = 2;

  logic        clock;
  logic        nreset;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_error;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_address;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        fault;

  instruction_fetch #(
    .RESET_VECTOR (RV),
    .DEPTH        (DEPTH)
  ) dut (
    .clock           (clock),
    .nreset          (nreset),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_addr    (mem_req_addr),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_data   (mem_resp_data),
    .mem_resp_error  (mem_resp_error),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_address     (out_address),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .fault           (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  typedef struct {
    logic [31:0] addr;
    int          cyc;
  } req_rec_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    int          cyc;
  } pop_rec_t;

  mreq_t    memq[$];
  req_rec_t req_log[$];
  pop_rec_t pop_log[$];

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int lat        = 1;
  int err_cyc    = -1;
  bit rand_ready = 0;
  bit rand_lat   = 0;
  bit err_en     = 0;
  logic [31:0] err_addr = '0;

  logic        s_rv, s_ov, s_flt, s_fire, s_pop;
  logic [31:0] s_ra, s_oa, s_oi;
  int          s_cyc;

  function automatic logic [31:0] instr_of(
    input logic [31:0] a
  );
    return {a[15:0] ^ 16'h5A3C,
            a[31:16] ^ a[15:0] ^ 16'hC001};
  endfunction

  // one clock: sample at negedge, then memory drives next cycle
  task automatic tick();
    int d;
    @(negedge clock);
    s_cyc  = cyc;
    s_rv   = mem_req_valid;
    s_ra   = mem_req_addr;
    s_ov   = out_valid;
    s_oa   = out_address;
    s_oi   = out_instruction;
    s_flt  = fault;
    s_fire = s_rv && mem_req_ready;
    s_pop  = s_ov && out_ready;
    if (s_fire) begin
      if (rand_lat) d = cyc + int'($urandom_range(1, 4));
      else          d = cyc + lat;
      if (memq.size() > 0 && d <= memq[$].due)
        d = memq[$].due + 1;
      memq.push_back('{addr: s_ra, due: d});
      req_log.push_back('{addr: s_ra, cyc: cyc});
    end
    if (s_pop)
      pop_log.push_back('{addr: s_oa, instr: s_oi,
                          cyc: cyc});
    @(posedge clock);
    cyc++;
    #1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = $urandom;
    mem_resp_error = 1'b0;
    if (memq.size() > 0 && memq[0].due == cyc) begin
      mreq_t e;
      e = memq.pop_front();
      mem_resp_valid = 1'b1;
      mem_resp_data  = instr_of(e.addr);
      if (err_en && e.addr == err_addr) begin
        mem_resp_error = 1'b1;
        err_cyc        = cyc;
      end
    end
    mem_req_ready = rand_ready ? 1'($urandom_range(0, 1))
                               : 1'b1;
  endtask

  task automatic do_reset();
    nreset         = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    out_ready      = 1'b0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    mem_resp_error = 1'b0;
    rand_ready     = 0;
    rand_lat       = 0;
    err_en         = 0;
    err_cyc        = -1;
    lat            = 1;
    memq.delete();
    req_log.delete();
    pop_log.delete();
    repeat (2) @(posedge clock);
    #1;
    nreset = 1'b1;
    cyc    = 0;
  endtask

  // one-cycle redirect; returns cycle the target fetch must issue
  task automatic redirect_to(
    input  logic [31:0] t,
    output int          first_req
  );
    redirect_valid  = 1'b1;
    redirect_target = t;
    first_req = (memq.size() == 0) ? cyc + 1
                                   : memq[$].due + 1;
    tick();
    redirect_valid = 1'b0;
    req_log.delete();
    pop_log.delete();
  endtask

  task automatic test_reset();
    nreset         = 1'b0;
    redirect_valid = 1'b0;
    mem_req_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_resp_valid = 1'($urandom_range(0, 1));
      mem_resp_data  = $urandom;
      out_ready      = 1'($urandom_range(0, 1));
      @(negedge clock);
      vectors++;
      if (mem_req_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_req: got %b expected 0",
                 mem_req_valid);
      end
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_out_valid: got %b expected 0",
                 out_valid);
      end
      vectors++;
      if (fault !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_fault: got %b expected 0",
                 fault);
      end
    end
    do_reset();
    tick();
    vectors++;
    if (s_rv !== 1'b1 || s_ra !== RV) begin
      miscompares++;
      $display("FAIL first_req: got v=%b a=%h expected v=1 a=%h",
               s_rv, s_ra, RV);
    end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    repeat (20) tick();
    vectors++;
    if (pop_log.size() != 18) begin
      miscompares++;
      $display("FAIL stream_count: got %0d expected 18",
               pop_log.size());
    end
    foreach (pop_log[k]) begin
      logic [31:0] ea;
      ea = RV + 32'(4 * k);
      vectors++;
      if (pop_log[k].addr !== ea
          || pop_log[k].cyc != 2 + k
          || pop_log[k].instr !== instr_of(ea)) begin
        miscompares++;
        $display("FAIL stream[%0d]: got a=%h c=%0d i=%h expected a=%h c=%0d i=%h",
                 k, pop_log[k].addr, pop_log[k].cyc,
                 pop_log[k].instr, ea, 2 + k,
                 instr_of(ea));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_cyc >= 2) begin
        vectors++;
        if (s_ov !== 1'b1 || s_oa !== RV) begin
          miscompares++;
          $display("FAIL stall_head c%0d: got v=%b a=%h expected v=1 a=%h",
                   s_cyc, s_ov, s_oa, RV);
        end
      end
    end
    vectors++;
    if (req_log.size() != DEPTH) begin
      miscompares++;
      $display("FAIL stall_reqs: got %0d expected %0d",
               req_log.size(), DEPTH);
    end
    out_ready = 1'b1;
    req_log.delete();
    pop_log.delete();
    repeat (10) tick();
    vectors++;
    if (pop_log.size() != 10) begin
      miscompares++;
      $display("FAIL release_count: got %0d expected 10",
               pop_log.size());
    end
    foreach (pop_log[k]) begin
      vectors++;
      if (pop_log[k].addr !== RV + 32'(4 * k)
          || pop_log[k].cyc != 10 + k) begin
        miscompares++;
        $display("FAIL release[%0d]: got a=%h c=%0d expected a=%h c=%0d",
                 k, pop_log[k].addr, pop_log[k].cyc,
                 RV + 32'(4 * k), 10 + k);
      end
    end
    vectors++;
    if (req_log.size() == 0
        || req_log[0].addr !== RV + 32'd8
        || req_log[0].cyc != 10) begin
      miscompares++;
      $display("FAIL resume_req: got n=%0d expected a=%h at c10",
               req_log.size(), RV + 32'd8);
    end
  endtask

  task automatic test_redirect_drain();
    int fr;
    do_reset();
    lat       = 3;
    out_ready = 1'b1;
    repeat (2) tick();
    redirect_to(32'h100, fr);
    tick();
    vectors++;
    if (s_ov !== 1'b0 || s_rv !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_n1: got ov=%b rv=%b expected 0 0",
               s_ov, s_rv);
    end
    repeat (12) tick();
    vectors++;
    if (req_log.size() == 0
        || req_log[0].addr !== 32'h100
        || req_log[0].cyc != fr) begin
      miscompares++;
      $display("FAIL drain_req: got n=%0d expected a=100 c=%0d",
               req_log.size(), fr);
    end
    vectors++;
    if (pop_log.size() < 2) begin
      miscompares++;
      $display("FAIL drain_pops: got %0d expected >=2",
               pop_log.size());
    end
    foreach (pop_log[k]) begin
      vectors++;
      if (pop_log[k].addr !== 32'h100 + 32'(4 * k)) begin
        miscompares++;
        $display("FAIL drain_pop[%0d]: got %h expected %h",
                 k, pop_log[k].addr,
                 32'h100 + 32'(4 * k));
      end
    end
  endtask

  task automatic test_redirect_coincident();
    int fr;
    do_reset();
    out_ready = 1'b1;
    repeat (6) tick();
    redirect_to(32'h300, fr);
    tick();
    vectors++;
    if (s_ov !== 1'b0) begin
      miscompares++;
      $display("FAIL coin_n1: got ov=%b expected 0", s_ov);
    end
    repeat (10) tick();
    vectors++;
    if (req_log.size() == 0
        || req_log[0].addr !== 32'h300
        || req_log[0].cyc != fr) begin
      miscompares++;
      $display("FAIL coin_req: got n=%0d expected a=300 c=%0d",
               req_log.size(), fr);
    end
    vectors++;
    if (pop_log.size() == 0
        || pop_log[0].addr !== 32'h300
        || pop_log[0].cyc != fr + 2) begin
      miscompares++;
      $display("FAIL coin_first: got n=%0d expected a=300 c=%0d",
               pop_log.size(), fr + 2);
    end
    foreach (pop_log[k]) begin
      vectors++;
      if (pop_log[k].addr !== 32'h300 + 32'(4 * k)) begin
        miscompares++;
        $display("FAIL coin_pop[%0d]: got %h expected %h",
                 k, pop_log[k].addr,
                 32'h300 + 32'(4 * k));
      end
    end
  endtask

  task automatic test_bus_error();
    int fr;
    int fault_cyc;
    int late;
    do_reset();
    out_ready = 1'b1;
    err_en    = 1;
    err_addr  = RV + 32'd4;
    fault_cyc = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (s_flt && fault_cyc < 0) fault_cyc = s_cyc;
    end
    vectors++;
    if (pop_log.size() != 1 || pop_log[0].addr !== RV) begin
      miscompares++;
      $display("FAIL err_pops: got n=%0d expected only %h",
               pop_log.size(), RV);
    end
    vectors++;
    if (err_cyc < 0 || fault_cyc != err_cyc + 1) begin
      miscompares++;
      $display("FAIL err_fault_cyc: got %0d expected %0d",
               fault_cyc, err_cyc + 1);
    end
    late = 0;
    foreach (req_log[k])
      if (req_log[k].cyc > err_cyc) late++;
    vectors++;
    if (late != 0) begin
      miscompares++;
      $display("FAIL err_reqs: got %0d expected 0", late);
    end
    vectors++;
    if (s_flt !== 1'b1 || s_ov !== 1'b0) begin
      miscompares++;
      $display("FAIL err_hold: got f=%b ov=%b expected 1 0",
               s_flt, s_ov);
    end
    err_en = 0;
    redirect_to(32'h200, fr);
    tick();
    vectors++;
    if (s_flt !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear: got %b expected 0", s_flt);
    end
    repeat (8) tick();
    vectors++;
    if (req_log.size() == 0
        || req_log[0].addr !== 32'h200
        || req_log[0].cyc != fr) begin
      miscompares++;
      $display("FAIL err_refetch: got n=%0d expected a=200 c=%0d",
               req_log.size(), fr);
    end
    vectors++;
    if (pop_log.size() < 2
        || pop_log[0].addr !== 32'h200
        || pop_log[1].addr !== 32'h204) begin
      miscompares++;
      $display("FAIL err_redeliver: got n=%0d expected 200,204",
               pop_log.size());
    end
  endtask

  task automatic test_misaligned_wrap();
    int fr;
    do_reset();
    out_ready = 1'b1;
    repeat (3) tick();
    redirect_to(32'h102, fr);
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (s_flt !== 1'b1 || s_rv !== 1'b0) begin
        miscompares++;
        $display("FAIL misalign c%0d: got f=%b rv=%b expected 1 0",
                 s_cyc, s_flt, s_rv);
      end
    end
    vectors++;
    if (pop_log.size() != 0) begin
      miscompares++;
      $display("FAIL misalign_pops: got %0d expected 0",
               pop_log.size());
    end
    redirect_to(32'hFFFF_FFFC, fr);
    repeat (8) tick();
    vectors++;
    if (s_flt !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_fault: got %b expected 0", s_flt);
    end
    vectors++;
    if (req_log.size() < 2
        || req_log[0].addr !== 32'hFFFF_FFFC
        || req_log[0].cyc != fr
        || req_log[1].addr !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_reqs: got n=%0d expected fffffffc@%0d,0",
               req_log.size(), fr);
    end
    vectors++;
    if (pop_log.size() < 3
        || pop_log[0].addr !== 32'hFFFF_FFFC
        || pop_log[1].addr !== 32'h0
        || pop_log[2].addr !== 32'h4) begin
      miscompares++;
      $display("FAIL wrap_pops: got n=%0d expected fffffffc,0,4",
               pop_log.size());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b1;
    repeat (5) tick();
    #2;
    nreset = 1'b0;
    #1;
    vectors++;
    if (mem_req_valid !== 1'b0 || out_valid !== 1'b0
        || fault !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got rv=%b ov=%b f=%b expected 0 0 0",
               mem_req_valid, out_valid, fault);
    end
    do_reset();
    out_ready = 1'b1;
    tick();
    vectors++;
    if (s_rv !== 1'b1 || s_ra !== RV || s_ov !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset: got rv=%b a=%h ov=%b expected 1 %h 0",
               s_rv, s_ra, s_ov, RV);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_req, exp_pop, tgt;
    bit          halted, rdir;
    do_reset();
    rand_ready = 1;
    rand_lat   = 1;
    exp_req    = RV;
    exp_pop    = RV;
    halted     = 0;
    tgt        = '0;
    for (int i = 0; i < 3000; i++) begin
      rdir = ($urandom_range(0, 39) == 0);
      if (rdir) begin
        tgt = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 7) == 0)
          tgt[1:0] = 2'($urandom_range(1, 3));
      end
      redirect_valid  = rdir;
      redirect_target = tgt;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      vectors++;
      if (s_flt !== halted) begin
        miscompares++;
        $display("FAIL rnd_fault c%0d: got %b expected %b",
                 s_cyc, s_flt, halted);
      end
      if (rdir || halted) begin
        vectors++;
        if (s_rv !== 1'b0) begin
          miscompares++;
          $display("FAIL rnd_req_quiet c%0d: got %b expected 0",
                   s_cyc, s_rv);
        end
      end
      if (halted) begin
        vectors++;
        if (s_ov !== 1'b0) begin
          miscompares++;
          $display("FAIL rnd_out_quiet c%0d: got %b expected 0",
                   s_cyc, s_ov);
        end
      end
      if (s_fire) begin
        vectors++;
        if (s_ra !== exp_req) begin
          miscompares++;
          $display("FAIL rnd_req c%0d: got %h expected %h",
                   s_cyc, s_ra, exp_req);
        end
        exp_req = s_ra + 32'd4;
      end
      if (s_pop) begin
        vectors++;
        if (s_oa !== exp_pop
            || s_oi !== instr_of(exp_pop)) begin
          miscompares++;
          $display("FAIL rnd_pop c%0d: got a=%h i=%h expected a=%h i=%h",
                   s_cyc, s_oa, s_oi, exp_pop,
                   instr_of(exp_pop));
        end
        exp_pop = s_oa + 32'd4;
      end
      vectors++;
      if (memq.size() > DEPTH) begin
        miscompares++;
        $display("FAIL rnd_credit c%0d: got %0d expected <=%0d",
                 s_cyc, memq.size(), DEPTH);
      end
      if (rdir) begin
        exp_req = tgt;
        exp_pop = tgt;
        halted  = (tgt[1:0] != 2'b00);
      end
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drain();
    test_redirect_coincident();
    test_bus_error();
    test_misaligned_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
